spi_byte_slave: RTL

SPI mode-0 slave front end for the Titan comms path. Oversamples the external SPI pins (SCLK, CS_N, MOSI) in the system clock domain and assembles MSB-first bytes. Presents each byte as `rx_byte_o` with a one-cycle `rx_valid_o` strobe directly to the instruction handler's `spi_rx_valid_i` / `spi_rx_byte_i`. Serialises the handler's `spi_tx_byte_o` back out on MISO, giving a full-duplex byte channel.

---
 rtl/spi_byte_slave.sv | 121 ++++++++++++
 1 files changed

// File: rtl/spi_byte_slave.sv
`timescale 1ns/1ps
// SPI mode-0 byte slave: oversamples SCLK/CS_N/MOSI in the clk_i domain, assembles MSB-first
// receive bytes and shifts the handler's transmit byte out on MISO.
module spi_byte_slave #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       sclk_i,
    input  logic       cs_ni,
    input  logic       mosi_i,
    output logic       miso_o,
    input  logic [7:0] tx_byte_i,
    output logic [7:0] rx_byte_o,
    output logic       rx_valid_o,
    output logic       busy_o
);

    typedef enum logic [0:0] {StIdle, StActive} state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_hist_q, cs_hist_q;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

    logic [2:0] bit_cnt_q;
    logic [7:0] rx_shift_q, tx_shift_q, rx_byte_q;
    logic       rx_valid_q;

    // CS chain resets to "low" so a CS held low across reset never looks like a frame start.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_hist_q <= 1'b0;
            cs_hist_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_ni};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            sclk_hist_q <= sclk_s;
            cs_hist_q   <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_hist_q;
    assign sclk_fall = ~sclk_s & sclk_hist_q;
    assign cs_fall   = ~cs_s & cs_hist_q;
    assign cs_rise   = cs_s & ~cs_hist_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (cs_rise) begin
            state_d = StIdle;
        end else if (state_q == StIdle && cs_fall) begin
            state_d = StActive;
        end
    end

    always_comb begin
        busy_o = (state_q == StActive);
        miso_o = tx_shift_q[7];
    end

    // cs_rise has priority over any SCLK edge in the same cycle and drops a partial byte.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bit_cnt_q  <= 3'd0;
            rx_shift_q <= 8'h00;
            tx_shift_q <= 8'h00;
            rx_byte_q  <= 8'h00;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (cs_rise) begin
                bit_cnt_q  <= 3'd0;
                rx_shift_q <= 8'h00;
                tx_shift_q <= 8'h00;
            end else if (state_q == StIdle) begin
                if (cs_fall) begin
                    tx_shift_q <= tx_byte_i;
                end
            end else begin
                if (sclk_rise) begin
                    rx_shift_q <= {rx_shift_q[6:0], mosi_s};
                    bit_cnt_q  <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_byte_q  <= {rx_shift_q[6:0], mosi_s};
                        rx_valid_q <= 1'b1;
                    end
                end
                if (sclk_fall) begin
                    // Counter back at zero means eight rising edges are done: fetch next byte.
                    if (bit_cnt_q == 3'd0) begin
                        tx_shift_q <= tx_byte_i;
                    end else begin
                        tx_shift_q <= {tx_shift_q[6:0], 1'b0};
                    end
                end
            end
        end
    end

    assign rx_byte_o  = rx_byte_q;
    assign rx_valid_o = rx_valid_q;

endmodule
